// File: rtl/bcd_converter_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DIGIT_W = 4;

    // Double-dabble correction: a nibble >= 5 gets +3 before the shift
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    // Saturation ceiling, used only when SATURATE_999_EN is defined
    localparam int unsigned                      SAT_VALUE  = 999;
    localparam int unsigned                      SAT_DIGITS = 3;
    localparam logic [SAT_DIGITS*DIGIT_W-1:0]    SAT_BCD    = 12'h999;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-nibble double-dabble correction: adds 3 to any digit of 5 or more.
module bcd_digit_adjust
    import bcd_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

// File: rtl/bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Optional build macro SATURATE_999_EN clamps results above 999 to 0x0999
// and raises ovf_o; without it ovf_o is tied low.
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [WIDTH-1:0]            bin_i,
    output logic                        ready_o,
    output logic                        done_o,
    output logic [DIGITS*DIGIT_W-1:0]   bcd_o,
    output logic                        ovf_o
);

    localparam int unsigned BCD_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       sr_q, sr_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   done_q, done_d;
    logic [BCD_W-1:0]       adj;
    logic [BCD_W+WIDTH-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef SATURATE_999_EN
    logic ovf_q, ovf_d;
    logic over;

    // Value exceeds 999 when any digit above the hundreds is nonzero
    always_comb begin
        over = 1'b0;
        for (int unsigned i = SAT_DIGITS; i < DIGITS; i++) begin
            if (scratch_q[i*DIGIT_W +: DIGIT_W] != '0) begin
                over = 1'b1;
            end
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    // Next-state, datapath and output-register update
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        shifted   = {adj, sr_q} << 1;
`ifdef SATURATE_999_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sr_d      = bin_i;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, sr_d} = shifted;
                cnt_d = cnt_q - CNT_ONE;
                if ((cnt_q == CNT_ONE) || (cnt_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef SATURATE_999_EN
                if (over) begin
                    bcd_d = '0;
                    bcd_d[SAT_DIGITS*DIGIT_W-1:0] = SAT_BCD;
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = scratch_q;
                    ovf_d = 1'b0;
                end
`else
                bcd_d = scratch_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
`ifdef SATURATE_999_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
`ifdef SATURATE_999_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign done_o  = done_q;
    assign bcd_o   = bcd_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter (WIDTH=12, DIGITS=4).
module tb_bcd_converter;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned DIGITS = 4;

`ifdef SATURATE_999_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        start_i = 1'b0;
    logic [11:0] bin_i   = '0;
    logic        ready_o;
    logic        done_o;
    logic [15:0] bcd_o;
    logic        ovf_o;

    int nvec = 0;
    int nerr = 0;

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .bin_i   (bin_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned t;
        r = '0;
        t = v;
        if (SAT && v > 999) return 16'h0999;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v);
        return SAT && (v > 999);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the done pulse; lat counts edges since the accept edge
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (done_o !== 1'b1 && lat < 40);
    endtask

    // Single accepted conversion; bin_i is scrambled right after acceptance
    task automatic conv(input logic [11:0] v, output int lat);
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = v;
        @(posedge clk);
        #1;
        check("accept", ready_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        bin_i   = ~v;
        wait_done(lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ndone;
        logic [15:0] cap;

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_done",  done_o,  0);
        check("rst_bcd",   bcd_o,   16'h0000);
        check("rst_ovf",   ovf_o,   0);

        // First edge with rst_n high accepts 1234
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        start_i = 1'b1;
        bin_i   = 12'd1234;
        @(posedge clk);
        #1;
        check("acc_first_edge", ready_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        bin_i   = 12'hABC;
        wait_done(lat);
        check("lat_1234",   lat,     13);
        check("bcd_1234",   bcd_o,   16'h1234);
        check("ovf_1234",   ovf_o,   0);
        check("ready_done", ready_o, 1);
        @(posedge clk);
        #1;
        check("done_pulse_1", done_o, 0);
        check("bcd_held",     bcd_o,  16'h1234);

        // Back-to-back 0 then 4095 with start held high
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 12'd0;
        @(posedge clk);
        #1;
        check("acc_zero", ready_o, 0);
        @(negedge clk);
        bin_i = 12'd4095;
        wait_done(lat);
        check("lat_zero", lat,   13);
        check("bcd_zero", bcd_o, 16'h0000);
        @(posedge clk);
        #1;
        check("acc_4095_b2b", ready_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        wait_done(lat);
        check("lat_4095", lat,   13);
        check("bcd_4095", bcd_o, ref_bcd(4095));
        check("ovf_4095", ovf_o, ref_ovf(4095));

        // Start pulse while busy is ignored
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 12'd567;
        @(posedge clk);
        #1;
        check("acc_567", ready_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        ndone = 0;
        lat   = 0;
        cap   = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) begin
                start_i = 1'b1;
                bin_i   = 12'd111;
            end
            if (i == 4) start_i = 1'b0;
            @(posedge clk);
            #1;
            if (done_o === 1'b1) begin
                ndone++;
                lat = i;
                cap = bcd_o;
            end
        end
        check("busy_ndone", ndone, 1);
        check("busy_lat",   lat,   13);
        check("busy_bcd",   cap,   16'h0567);

        // Reset mid-conversion aborts without a done pulse
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 12'd999;
        @(posedge clk);
        #1;
        check("acc_999", ready_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready_o, 1);
        check("abort_done",  done_o,  0);
        check("abort_bcd",   bcd_o,   16'h0000);
        check("abort_ovf",   ovf_o,   0);
        @(posedge clk);
        #1;
        check("abort_done_c1", done_o, 0);
        @(posedge clk);
        #1;
        check("abort_done_c2", done_o, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        start_i = 1'b1;
        bin_i   = 12'd42;
        @(posedge clk);
        #1;
        check("acc_42", ready_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        wait_done(lat);
        check("lat_42", lat,   13);
        check("bcd_42", bcd_o, 16'h0042);

        // Saturation boundary
        conv(12'd1000, lat);
        check("lat_1000", lat,   13);
        check("bcd_1000", bcd_o, SAT ? 16'h0999 : 16'h1000);
        check("ovf_1000", ovf_o, SAT ? 1 : 0);
        conv(12'd998, lat);
        check("lat_998", lat,   13);
        check("bcd_998", bcd_o, 16'h0998);
        check("ovf_998", ovf_o, 0);

        // Full sweep, start held high so every value follows back-to-back
        @(negedge clk);
        start_i = 1'b1;
        bin_i   = 12'd0;
        for (int unsigned v = 0; v < 4096; v++) begin
            @(posedge clk);
            #1;
            bin_i = 12'(v + 1);
            if (v == 4095) start_i = 1'b0;
            wait_done(lat);
            check("sweep_lat", lat, 13);
            check("sweep_res", {ovf_o, bcd_o}, {ref_ovf(v), ref_bcd(v)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 12, binary input width (matches the averaged display word).
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits; DIGITS*4 >= ceil(WIDTH*log10(2))*4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  request to convert bin_i; sampled only when ready_o=1.
REQ-006 bin_i  input  WIDTH  unsigned binary value, captured on the accepted start.
REQ-007 ready_o  output  1  high in IDLE only.
REQ-008 done_o  output  1  one-cycle pulse when bcd_o is updated.
REQ-009 bcd_o  output  DIGITS*4  packed BCD result, digit 0 in bits [3:0]; held between conversions.
REQ-010 ovf_o  output  1  saturation flag, meaningful only with SATURATE_999_EN; otherwise tied 0.

Function
REQ-011 SHALL implement iterative double-dabble, one shift per clock.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013 IDLE -> SHIFT when start_i=1; bin_i captured into the shift register, BCD scratch cleared, iteration counter loaded with WIDTH.
REQ-014 In SHIFT, each cycle: every scratch digit >= 5 gets +3, then {scratch, shift register} shifts left by 1; counter decrements.
REQ-015 SHIFT -> DONE after exactly WIDTH shift cycles.
REQ-016 DONE SHALL last one cycle: bcd_o loaded from scratch, done_o=1, then -> IDLE.
REQ-017 Latency: start sampled at edge N -> done_o high and bcd_o valid in cycle N+WIDTH+1; next start accepted at edge N+WIDTH+2.
REQ-018 start_i while ready_o=0 SHALL be ignored (no queueing, no restart, no effect on result).
REQ-019 bin_i changes after acceptance SHALL not affect the conversion.
REQ-020 bin_i=0 SHALL still take the full WIDTH+1 cycles and produce all-zero bcd_o.
REQ-021 Counter width SHALL be clog2(WIDTH+1); no wrap-around beyond WIDTH iterations.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, ready_o=1, done_o=0, bcd_o=0, ovf_o=0, scratch and counter cleared.
REQ-023 Reset mid-conversion SHALL abort it; no done_o pulse is produced for the aborted request.
REQ-024 First start after reset release SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-025 Macro SATURATE_999_EN defined: in DONE, if the converted value > 999, bcd_o SHALL be loaded with 0x0999 (upper digits zero) and ovf_o=1 until the next done_o; else ovf_o=0.
REQ-026 Macro undefined: bcd_o SHALL carry the full unsaturated result and ovf_o SHALL be constant 0.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, BCD digit width constant (4), adjust threshold (5), adjust addend (3), and saturation value (999 / 0x0999).
REQ-028 One sub-module bcd_digit_adjust SHALL implement the per-nibble conditional +3, instantiated DIGITS times via generate.
REQ-029 Block SHALL sit between the averaging stage and the seven-segment display driver; no other sub-modules.

Verification
REQ-030 Reset, start with bin_i=1234 -> done_o pulse exactly 13 cycles after accept, bcd_o=0x1234, ovf_o=0.
REQ-031 bin_i=0 then bin_i=4095 back-to-back (start held high) -> bcd_o=0x0000 then 0x4095, accepts 14 cycles apart (macro undefined).
REQ-032 start with 567, pulse start with 111 three cycles later -> single done_o, bcd_o=0x0567.
REQ-033 start with 999, assert rst_n low at cycle 5 for 2 cycles -> no done_o, bcd_o=0, ready_o=1; then start 42 -> bcd_o=0x0042.
REQ-034 SATURATE_999_EN defined: 1000 -> bcd_o=0x0999, ovf_o=1; then 998 -> bcd_o=0x0998, ovf_o=0.
REQ-035 Exhaustive sweep 0..4095 against reference decimal model -> every result matches, done_o exactly once per accept.
